// File: rtl/softusb_timerx.sv
// Multi-channel timer/counter on the navre I/O bus: shared 15-bit prescaler plus CHANNELS preloadable counters.
// Define SOFTUSB_TIMERX_SHADOW_EN to latch val[WIDTH-1:8] on a VAL_LO read so that VAL_HI reads are coherent.
module softusb_timerx_chan #(
  parameter int WIDTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] taps_i,
  input  logic       we_i,
  input  logic       re_i,
  input  logic [2:0] off_i,
  input  logic [7:0] di_i,
  input  logic       ack_i,
  output logic [7:0] rd_o,
  output logic       pend_o
);
  localparam logic [2:0] OFF_CTRL = 3'd0, OFF_VLO = 3'd1, OFF_VHI = 3'd2,
                         OFF_TLO  = 3'd3, OFF_THI = 3'd4, OFF_STAT = 3'd5;
  // Narrow counters have no VAL_HI, so the VAL_LO write commits directly.
  localparam logic [2:0] OFF_COMMIT = (WIDTH == 8) ? OFF_VLO : OFF_VHI;

  logic [WIDTH-1:0] val_q, val_d, top_q, top_d;
  logic [7:0]       stg_q, stg_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, en_d, ien_q, ien_d, ar_q, ar_d, pend_q, pend_d;
  logic [15:0]      val16, top16, cval16, topw;
  logic [7:0]       hi;
  logic             tick, match, commit;

  assign val16  = 16'(val_q);
  assign top16  = 16'(top_q);
  assign cval16 = (WIDTH == 8) ? {8'h00, di_i} : {di_i, stg_q};
  assign tick   = en_q & taps_i[sel_q];
  assign match  = tick && (val_q == top_q);
  assign commit = we_i && (off_i == OFF_COMMIT);

  always_comb begin
    en_d   = en_q;
    ien_d  = ien_q;
    ar_d   = ar_q;
    sel_d  = sel_q;
    stg_d  = stg_q;
    val_d  = val_q;
    pend_d = pend_q;
    topw   = top16;
    if (match && !ar_q) en_d = 1'b0;
    // A CTRL write lands after the one-shot disable so software wins.
    if (we_i && off_i == OFF_CTRL) begin
      en_d  = di_i[0];
      ien_d = di_i[1];
      ar_d  = di_i[2];
      sel_d = di_i[5:4];
    end
    if (we_i && off_i == OFF_VLO) stg_d = di_i;
    if (commit)    val_d = cval16[WIDTH-1:0];
    else if (tick) val_d = match ? (ar_q ? '0 : val_q) : val_q + WIDTH'(1);
    if (we_i && off_i == OFF_TLO) topw[7:0]  = di_i;
    if (we_i && off_i == OFF_THI) topw[15:8] = di_i;
    top_d = topw[WIDTH-1:0];
    // Set after clear: a match coinciding with an ack is never lost.
    if (ack_i || (we_i && off_i == OFF_STAT && di_i[0])) pend_d = 1'b0;
    if (match && ien_q) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q  <= '0;
      top_q  <= '0;
      stg_q  <= '0;
      sel_q  <= '0;
      en_q   <= 1'b0;
      ien_q  <= 1'b0;
      ar_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      top_q  <= top_d;
      stg_q  <= stg_d;
      sel_q  <= sel_d;
      en_q   <= en_d;
      ien_q  <= ien_d;
      ar_q   <= ar_d;
      pend_q <= pend_d;
    end
  end

`ifdef SOFTUSB_TIMERX_SHADOW_EN
  logic [7:0] shd_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       shd_q <= '0;
    else if (re_i && off_i == OFF_VLO) shd_q <= val16[15:8];
  end
  assign hi = shd_q;
`else
  assign hi = val16[15:8];
`endif

  always_comb begin
    rd_o = 8'h00;
    if (re_i) begin
      case (off_i)
        OFF_CTRL: rd_o = {2'b00, sel_q, 1'b0, ar_q, ien_q, en_q};
        OFF_VLO:  rd_o = val16[7:0];
        OFF_VHI:  rd_o = hi;
        OFF_TLO:  rd_o = top16[7:0];
        OFF_THI:  rd_o = top16[15:8];
        OFF_STAT: rd_o = {6'b000000, en_q, pend_q};
        default:  rd_o = 8'h00;
      endcase
    end
  end

  assign pend_o = pend_q;
endmodule

module softusb_timerx #(
  parameter int          CHANNELS = 4,
  parameter int          WIDTH    = 16,
  parameter logic [5:0]  BASE     = 6'h20
) (
  input  logic                usb_clk,
  input  logic                usb_rst_n,
  input  logic                io_re,
  input  logic                io_we,
  input  logic [5:0]          io_a,
  input  logic [7:0]          io_di,
  output logic [7:0]          io_do,
  output logic [CHANNELS-1:0] irq,
  input  logic [CHANNELS-1:0] irq_ack
);
  logic [14:0]                pre_q;
  logic [3:0]                 taps;
  logic [6:0]                 rel;
  logic [2:0]                 ch;
  logic                       hit;
  logic [CHANNELS-1:0]        sel;
  logic [CHANNELS-1:0][7:0]   rd;
  logic [7:0]                 io_do_q, io_do_d;

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) pre_q <= '0;
    else            pre_q <= pre_q + 15'd1;
  end

  assign taps = {pre_q == '0, pre_q[10:0] == 11'd0, pre_q[6:0] == 7'd0, 1'b1};
  // Borrow in rel[6] marks addresses below BASE.
  assign rel  = {1'b0, io_a} - {1'b0, BASE};
  assign ch   = rel[5:3];
  assign hit  = !rel[6] && (int'(ch) < CHANNELS);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign sel[c] = hit && (int'(ch) == c);
    softusb_timerx_chan #(.WIDTH(WIDTH)) u_ch (
      .clk_i  (usb_clk),
      .rst_ni (usb_rst_n),
      .taps_i (taps),
      .we_i   (io_we & sel[c]),
      .re_i   (io_re & sel[c]),
      .off_i  (rel[2:0]),
      .di_i   (io_di),
      .ack_i  (irq_ack[c]),
      .rd_o   (rd[c]),
      .pend_o (irq[c])
    );
  end

  always_comb begin
    io_do_d = 8'h00;
    for (int c = 0; c < CHANNELS; c++) io_do_d = io_do_d | rd[c];
  end

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) io_do_q <= '0;
    else            io_do_q <= io_do_d;
  end

  assign io_do = io_do_q;
endmodule

// File: tb/tb_softusb_timerx.sv
// Scoreboarded bench for softusb_timerx: main 4x16 instance plus a 1x8 instance sharing the I/O bus.
module tb_softusb_timerx;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       io_re = 1'b0, io_we = 1'b0;
  logic [5:0] io_a = '0;
  logic [7:0] io_di = '0;
  logic [7:0] io_do, io_do8, got, want, got8;
  logic [3:0] irq, irq_ack = '0;
  logic [0:0] irq8, irq_ack8 = '0;
  int         cyc, n_chk = 0, n_fail = 0, k_rise;
  logic [7:0] exp_q[$];

  softusb_timerx dut (.usb_clk(clk), .usb_rst_n(rst_n), .io_re(io_re), .io_we(io_we), .io_a(io_a),
    .io_di(io_di), .io_do(io_do), .irq(irq), .irq_ack(irq_ack));
  softusb_timerx #(.CHANNELS(1), .WIDTH(8)) dut8 (.usb_clk(clk), .usb_rst_n(rst_n), .io_re(io_re),
    .io_we(io_we), .io_a(io_a), .io_di(io_di), .io_do(io_do8), .irq(irq8), .irq_ack(irq_ack8));

  always #5 clk = ~clk;
  // Counts posedges since reset release; tracks the DUT prescaler one-for-one.
  always @(posedge clk or negedge rst_n) if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    io_we = 1'b1; io_a = a; io_di = d;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] e, output logic [7:0] g, output logic [7:0] w);
    exp_q.push_back(e);
    io_re = 1'b1; io_a = a;
    @(negedge clk);
    g = io_do; got8 = io_do8; io_re = 1'b0;
    w = exp_q.pop_front();
  endtask

  task automatic wait_irq(input int idx, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if ((idx < 4 && irq[idx]) || (idx == 4 && irq8[0])) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    n_chk++; if (irq !== 4'h0) begin n_fail++; $display("FAIL reset_irq got %h want 0", irq); end
    rd(6'h20, 8'h00, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL reset_ctrl got %h want %h", got, want); end
    rd(6'h3D, 8'h00, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL reset_stat got %h want %h", got, want); end
    wr(6'h27, 8'hFF);
    rd(6'h27, 8'h00, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL reserved got %h want %h", got, want); end
    rd(6'h10, 8'h00, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL unmapped got %h want %h", got, want); end
  endtask

  task automatic test_autoreload;
    int c0; bit ok;
    wr(6'h23, 8'h05); wr(6'h24, 8'h00);
    c0 = cyc;
    wr(6'h20, 8'h07);
    wait_irq(0, 20, ok);
    n_chk++; if (!ok || cyc !== c0 + 7) begin n_fail++; $display("FAIL ar_first got cyc %0d want %0d", cyc, c0 + 7); end
    irq_ack[0] = 1'b1; @(negedge clk); irq_ack[0] = 1'b0;
    n_chk++; if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL ar_ack got %b want 0", irq[0]); end
    wait_irq(0, 20, ok);
    n_chk++; if (!ok || cyc !== c0 + 13) begin n_fail++; $display("FAIL ar_period got cyc %0d want %0d", cyc, c0 + 13); end
    k_rise = cyc;
  endtask

  task automatic test_set_clear;
    irq_ack[0] = 1'b1; @(negedge clk); irq_ack[0] = 1'b0;
    repeat (4) @(negedge clk);
    irq_ack[0] = 1'b1; @(negedge clk); irq_ack[0] = 1'b0;
    n_chk++; if (irq[0] !== 1'b1 || cyc !== k_rise + 6) begin n_fail++; $display("FAIL setclr got irq %b cyc %0d want 1 %0d", irq[0], cyc, k_rise + 6); end
    wr(6'h20, 8'h05);
    n_chk++; if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL ien_clear got %b want 1", irq[0]); end
    wr(6'h20, 8'h00);
    rd(6'h25, 8'h01, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL stat_pend got %h want %h", got, want); end
    wr(6'h25, 8'h01);
    n_chk++; if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL stat_clr got %b want 0", irq[0]); end
  endtask

  task automatic test_oneshot;
    int c0, n, t; bit ok;
    wr(6'h2B, 8'h02); wr(6'h2C, 8'h00);
    c0 = cyc;
    wr(6'h28, 8'h13);
    n = c0 + 1; t = 0;
    while (t < 3) begin n++; if (((n - 1) % 128) == 0) t++; end
    wait_irq(1, 600, ok);
    n_chk++; if (!ok || cyc !== n) begin n_fail++; $display("FAIL os_irq got cyc %0d want %0d", cyc, n); end
    n_chk++; if (irq !== 4'b0010) begin n_fail++; $display("FAIL os_irqvec got %b want 0010", irq); end
    rd(6'h2D, 8'h01, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL os_stat got %h want %h", got, want); end
    rd(6'h28, 8'h12, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL os_ctrl got %h want %h", got, want); end
    repeat (3) @(negedge clk);
    rd(6'h29, 8'h02, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL os_vallo got %h want %h", got, want); end
    rd(6'h2A, 8'h00, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL os_valhi got %h want %h", got, want); end
    irq_ack = 4'b0010; @(negedge clk); irq_ack = 4'b0000;
    n_chk++; if (irq[1] !== 1'b0) begin n_fail++; $display("FAIL os_ack got %b want 0", irq[1]); end
  endtask

  task automatic test_preload;
    wr(6'h33, 8'hFF); wr(6'h34, 8'hFF); wr(6'h30, 8'h01);
    wr(6'h31, 8'h34); wr(6'h32, 8'h12);
    rd(6'h31, 8'h34, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL pl_lo got %h want %h", got, want); end
    rd(6'h32, 8'h12, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL pl_hi got %h want %h", got, want); end
    rd(6'h31, 8'h36, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL pl_count got %h want %h", got, want); end
  endtask

  task automatic test_shadow;
    logic [7:0] e;
`ifdef SOFTUSB_TIMERX_SHADOW_EN
    e = 8'h00;
`else
    e = 8'h01;
`endif
    wr(6'h31, 8'hFF); wr(6'h32, 8'h00);
    rd(6'h31, 8'hFF, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL sh_lo got %h want %h", got, want); end
    repeat (2) @(negedge clk);
    rd(6'h32, e, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL sh_hi got %h want %h", got, want); end
    wr(6'h30, 8'h00);
  endtask

  task automatic test_reset_mid;
    wr(6'h3B, 8'h00); wr(6'h3C, 8'h00); wr(6'h38, 8'h07);
    repeat (2) @(negedge clk);
    n_chk++; if (irq !== 4'b1000) begin n_fail++; $display("FAIL rm_irq got %b want 1000", irq); end
    rd(6'h39, 8'h00, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL rm_val got %h want %h", got, want); end
    io_re = 1'b1; io_a = 6'h38;
    @(negedge clk);
    n_chk++; if (io_do !== 8'h07) begin n_fail++; $display("FAIL rm_do got %h want 07", io_do); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (irq !== 4'h0 || io_do !== 8'h00) begin n_fail++; $display("FAIL rm_async got irq %h do %h want 0 00", irq, io_do); end
    io_re = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd(6'h38, 8'h00, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL rm_ctrl got %h want %h", got, want); end
    rd(6'h2B, 8'h00, got, want);
    n_chk++; if (got !== want) begin n_fail++; $display("FAIL rm_top got %h want %h", got, want); end
  endtask

  task automatic test_width8;
    int c0; bit ok;
    wr(6'h24, 8'hAB);
    rd(6'h24, 8'hAB, got, want);
    n_chk++; if (got !== want || got8 !== 8'h00) begin n_fail++; $display("FAIL w8_tophi got %h/%h want %h/00", got, got8, want); end
    wr(6'h21, 8'h5A);
    rd(6'h21, 8'h00, got, want);
    n_chk++; if (got !== want || got8 !== 8'h5A) begin n_fail++; $display("FAIL w8_vallo got %h/%h want %h/5a", got, got8, want); end
    rd(6'h22, 8'h00, got, want);
    n_chk++; if (got !== want || got8 !== 8'h00) begin n_fail++; $display("FAIL w8_valhi got %h/%h want %h/00", got, got8, want); end
    wr(6'h28, 8'h34);
    rd(6'h28, 8'h34, got, want);
    n_chk++; if (got !== want || got8 !== 8'h00) begin n_fail++; $display("FAIL w8_ch1 got %h/%h want %h/00", got, got8, want); end
    wr(6'h21, 8'h00); wr(6'h23, 8'h03);
    c0 = cyc;
    wr(6'h20, 8'h07);
    wait_irq(4, 20, ok);
    n_chk++; if (!ok || cyc !== c0 + 5) begin n_fail++; $display("FAIL w8_match got cyc %0d want %0d", cyc, c0 + 5); end
    wr(6'h20, 8'h00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_autoreload;
    test_set_clear;
    test_oneshot;
    test_preload;
    test_shadow;
    test_reset_mid;
    test_width8;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
